// File: rtl/sh7604_dbus_arb_pkg.sv
// Shared types for the SH7604 data-bus arbiter: grant state encoding and burst beat constants.
package SH7604_PKG;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  // BEAT counts remaining beats after the current one; a 4-beat burst starts at 3.
  localparam logic [1:0] BEAT_BURST_INIT  = 2'd3;
  localparam logic [1:0] BEAT_SINGLE_INIT = 2'd0;

endpackage

// File: rtl/sh7604_dbus_arb.sv
// CPU/DMAC arbiter onto the BSC port: grant changes on CE_R, beats complete on CE_F, stalls are combinational.
// SH7604_ARB_FAIR_EN adds alternation via LAST_DMA; the default build is fixed DMA priority.
module sh7604_dbus_arb
  import SH7604_PKG::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DO,
  input  logic [3:0]  CPU_BA,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic        CPU_WAIT,
  input  logic [31:0] DMA_A,
  input  logic [31:0] DMA_DO,
  input  logic [3:0]  DMA_BA,
  input  logic        DMA_WE,
  input  logic        DMA_REQ,
  input  logic        DMA_LOCK,
  input  logic        DMA_BURST,
  output logic        DMA_WAIT,
  output logic        DMA_ACK,
  output logic [31:0] BUS_A,
  output logic [31:0] BUS_DO,
  output logic [3:0]  BUS_BA,
  output logic        BUS_WE,
  output logic        BUS_REQ,
  output logic        BUS_BURST,
  input  logic        BUS_WAIT
);

  arb_state_t r_state, w_state_nxt;
  logic [1:0] r_beat;
  logic       r_cpu_done, r_dma_fin;
  logic       w_cpu_beat, w_dma_beat, w_last_dma;
  logic       w_dma_exit;

  assign w_cpu_beat = (r_state == ARB_CPU) & CPU_REQ & ~BUS_WAIT;
  assign w_dma_beat = (r_state == ARB_DMA) & DMA_REQ & ~BUS_WAIT;
  assign w_dma_exit = ~DMA_LOCK & (r_dma_fin | ~DMA_REQ);

`ifdef SH7604_ARB_FAIR_EN
  logic r_last_dma;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last_dma <= 1'b0;
    end else if (CE_R && w_state_nxt == ARB_IDLE) begin
      if (r_state == ARB_DMA)      r_last_dma <= 1'b1;
      else if (r_state == ARB_CPU) r_last_dma <= 1'b0;
    end
  end

  assign w_last_dma = r_last_dma;
`else
  assign w_last_dma = 1'b0;
`endif

  // Release and grant are separate CE_R steps, so a handover always spends one CE_R in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (DMA_REQ && !(CPU_REQ && w_last_dma)) w_state_nxt = ARB_DMA;
        else if (CPU_REQ)                        w_state_nxt = ARB_CPU;
      end
      ARB_DMA: if (w_dma_exit) w_state_nxt = ARB_IDLE;
      ARB_CPU: if (!CPU_REQ || (r_cpu_done && DMA_REQ)) w_state_nxt = ARB_IDLE;
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ARB_IDLE;
    else if (CE_R) r_state <= w_state_nxt;
  end

  // Completion flags live for one rising period: set on CE_F, consumed and cleared on CE_R.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cpu_done <= 1'b0;
      r_dma_fin  <= 1'b0;
    end else begin
      if (CE_R) begin
        r_cpu_done <= 1'b0;
        r_dma_fin  <= 1'b0;
      end
      if (CE_F && w_cpu_beat) r_cpu_done <= 1'b1;
      if (CE_F && w_dma_beat && r_beat == 2'd0) r_dma_fin <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_beat <= 2'd0;
    end else if (CE_R && r_state == ARB_IDLE && w_state_nxt == ARB_DMA) begin
      r_beat <= DMA_BURST ? BEAT_BURST_INIT : BEAT_SINGLE_INIT;
    end else if (CE_R && r_state == ARB_DMA && !DMA_LOCK && !DMA_REQ) begin
      r_beat <= 2'd0;
    end else if (CE_F && w_dma_beat && r_beat != 2'd0) begin
      r_beat <= r_beat - 2'd1;
    end
  end

  always_comb begin
    BUS_A     = 32'd0;
    BUS_DO    = 32'd0;
    BUS_BA    = 4'd0;
    BUS_WE    = 1'b0;
    BUS_REQ   = 1'b0;
    BUS_BURST = 1'b0;
    case (r_state)
      ARB_CPU: begin
        BUS_A   = CPU_A;
        BUS_DO  = CPU_DO;
        BUS_BA  = CPU_BA;
        BUS_WE  = CPU_WE;
        BUS_REQ = CPU_REQ;
      end
      ARB_DMA: begin
        BUS_A     = DMA_A;
        BUS_DO    = DMA_DO;
        BUS_BA    = DMA_BA;
        BUS_WE    = DMA_WE;
        BUS_REQ   = DMA_REQ;
        BUS_BURST = DMA_BURST;
      end
      default: ;
    endcase
  end

  // Stalls are gated by RST_N so every output is quiet while reset is held.
  assign CPU_WAIT = RST_N & CPU_REQ & ((r_state != ARB_CPU) | BUS_WAIT);
  assign DMA_WAIT = RST_N & DMA_REQ & ((r_state != ARB_DMA) | BUS_WAIT);
  assign DMA_ACK  = (r_state == ARB_DMA) & DMA_REQ & ~BUS_WAIT;

endmodule

// File: doc/sh7604_dbus_arb.md
SH7604_DBUS_ARB -- requirements
Module: sh7604_dbus_arb

Interface
REQ-001 SHALL have port CLK  in  1  system clock.
REQ-002 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-003 SHALL have port CE_R  in  1  rising-phase clock enable; all grant-state updates occur only when CE_R=1.
REQ-004 SHALL have port CE_F  in  1  falling-phase clock enable; access completion is sampled only when CE_F=1.
REQ-005 SHALL have ports CPU_A/CPU_DO  in  32  CPU address and write data.
REQ-006 SHALL have port CPU_BA  in  4  CPU byte enables.
REQ-007 SHALL have ports CPU_WE/CPU_REQ  in  1  CPU write strobe and access request.
REQ-008 SHALL have port CPU_WAIT  out  1  CPU stall.
REQ-009 SHALL have ports DMA_A/DMA_DO  in  32  DMAC address and write data.
REQ-010 SHALL have port DMA_BA  in  4  DMAC byte enables.
REQ-011 SHALL have ports DMA_WE/DMA_REQ/DMA_LOCK/DMA_BURST  in  1  DMAC write, request, bus lock, 4-beat burst.
REQ-012 SHALL have ports DMA_WAIT/DMA_ACK  out  1  DMAC stall; DMAC beat acknowledge (BSC_ACK source).
REQ-013 SHALL have ports BUS_A/BUS_DO  out  32  BSC address and write data.
REQ-014 SHALL have port BUS_BA  out  4  BSC byte enables.
REQ-015 SHALL have ports BUS_WE/BUS_REQ/BUS_BURST  out  1  BSC write, request, burst.
REQ-016 SHALL have port BUS_WAIT  in  1  BSC not-ready; BSC read data goes to both masters outside this block.

Function
REQ-017 SHALL implement states IDLE, CPU_OWN, DMA_OWN.
REQ-018 SHALL, in IDLE on CE_R: go to DMA_OWN if DMA_REQ=1, else to CPU_OWN if CPU_REQ=1, else stay.
REQ-019 SHALL, on entry to DMA_OWN, load 2-bit BEAT with 3 if DMA_BURST=1, else 0.
REQ-020 SHALL count a beat complete on CE_F when the owner's REQ=1 and BUS_WAIT=0; a DMA beat with BEAT>0 decrements BEAT.
REQ-021 SHALL leave DMA_OWN for IDLE on CE_R only when DMA_LOCK=0 and either the final beat (BEAT=0) completed or DMA_REQ=0.
REQ-022 SHALL hold DMA_OWN while DMA_LOCK=1, even with DMA_REQ=0 (read-to-write turnaround).
REQ-023 SHALL leave CPU_OWN for IDLE on CE_R when CPU_REQ=0, or when a CPU beat completed and DMA_REQ=1.
REQ-024 SHALL drive BUS_A/DO/BA/WE/REQ from the owning master; all zero in IDLE.
REQ-025 SHALL drive CPU_WAIT = CPU_REQ & (state!=CPU_OWN | BUS_WAIT), combinational.
REQ-026 SHALL drive DMA_WAIT = DMA_REQ & (state!=DMA_OWN | BUS_WAIT), combinational.
REQ-027 SHALL drive DMA_ACK = (state==DMA_OWN) & DMA_REQ & ~BUS_WAIT.
REQ-028 SHALL drive BUS_BURST = (state==DMA_OWN) & DMA_BURST.
REQ-029 SHALL clear BEAT to 0 when DMA_REQ drops mid-burst with DMA_LOCK=0; remaining beats are abandoned.
REQ-030 SHALL never grant a master in the same CE_R in which the other master is released; handover always passes through IDLE for one CE_R.

Reset
REQ-031 SHALL, on RST_N=0, force state IDLE, BEAT=0, LAST_DMA=0 asynchronously; every output is then 0.
REQ-032 SHALL, on reset mid-burst, drop the burst with no completion or ACK emitted.

Configuration
REQ-033 SHALL, with SH7604_ARB_FAIR_EN defined, register LAST_DMA (set when leaving DMA_OWN, cleared when leaving CPU_OWN) and, in IDLE with both requests pending and LAST_DMA=1, grant CPU.
REQ-034 SHALL, without SH7604_ARB_FAIR_EN, use fixed DMA priority, with no LAST_DMA register.

Structure
REQ-035 SHALL place the state enum type (ARB_IDLE, ARB_CPU, ARB_DMA) in SH7604_PKG.
REQ-036 SHALL be a single module with no sub-modules.

Verification
REQ-037 SHALL cover: CPU_REQ alone, A=0x06000000, BUS_WAIT=0 -> CPU_OWN after one CE_R, BUS_A=0x06000000, CPU_WAIT=0.
REQ-038 SHALL cover: both requests in IDLE, macro off -> DMA_OWN, CPU_WAIT=1 until DMA releases.
REQ-039 SHALL cover: DMA_BURST=1, BUS_WAIT=1 for 2 CE_F before each beat -> exactly 4 DMA_ACK pulses, then IDLE.
REQ-040 SHALL cover: DMA_LOCK=1, DMA_REQ 1->0->1 -> no CPU grant in the gap, BUS_REQ=0 during the gap.
REQ-041 SHALL cover: macro on, both requesting continuously -> grants alternate DMA, CPU, DMA, CPU.
REQ-042 SHALL cover: RST_N asserted at beat 2 of a burst -> outputs 0 immediately; a later DMA_REQ starts a new burst with BEAT=3.
